// File: rtl/jtag_tap_pkg.sv
// Shared types for the debug TAP: state encoding, opcodes, DR selects and next-state rule.
// JTAG_TAP_CTRL_IDCODE_EN selects the IDCODE reset opcode (BYPASS otherwise).
package jtag_tap_pkg;

   // Standard IEEE 1149.1 state encoding, visible on the debug port
   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR_SCAN   = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR_SCAN   = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_e;

   typedef enum logic [2:0] {
      SEL_BYPASS,
      SEL_IDCODE,
      SEL_MEMORY,
      SEL_FIFO,
      SEL_CONFREG
   } dr_sel_e;

   localparam logic [3:0] OP_EXTEST         = 4'b0000;
   localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'b0001;
   localparam logic [3:0] OP_IDCODE         = 4'b0010;
   localparam logic [3:0] OP_MEMORY_ACCESS  = 4'b0100;
   localparam logic [3:0] OP_FIFO_ACCESS    = 4'b0101;
   localparam logic [3:0] OP_CONFREG_ACCESS = 4'b0110;
   localparam logic [3:0] OP_BYPASS         = 4'b1111;
   localparam logic [3:0] IR_CAPTURE_VALUE  = 4'b0101;

`ifdef JTAG_TAP_CTRL_IDCODE_EN
   localparam logic [3:0] OP_RESET = OP_IDCODE;
`else
   localparam logic [3:0] OP_RESET = OP_BYPASS;
`endif

   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      case (s)
         TEST_LOGIC_RESET: tap_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    tap_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   tap_next = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       tap_next = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         tap_next = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         tap_next = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         tap_next = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         tap_next = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        tap_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   tap_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       tap_next = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         tap_next = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         tap_next = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         tap_next = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         tap_next = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        tap_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          tap_next = TEST_LOGIC_RESET;
      endcase
   endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine with registered DR strobes that track the current state.
// Unaffected by JTAG_TAP_CTRL_IDCODE_EN.
module jtag_tap_fsm
   import jtag_tap_pkg::*;
(
   input  logic       tck_i,
   input  logic       trst_ni,
   input  logic       tms_i,
   output tap_state_e state_o,
   output logic       shift_dr_o,
   output logic       capture_dr_o,
   output logic       update_dr_o
);

   tap_state_e next_state;

   assign next_state = tap_next(state_o, tms_i);

   // Strobes are registered from the next state so they line up exactly with state_o
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         state_o      <= TEST_LOGIC_RESET;
         shift_dr_o   <= 1'b0;
         capture_dr_o <= 1'b0;
         update_dr_o  <= 1'b0;
      end else begin
         state_o      <= next_state;
         shift_dr_o   <= (next_state == SHIFT_DR);
         capture_dr_o <= (next_state == CAPTURE_DR);
         update_dr_o  <= (next_state == UPDATE_DR);
      end
   end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller for the debug scan chain: FSM, instruction register, DR selects, TDO mux.
// Define JTAG_TAP_CTRL_IDCODE_EN to include the IDCODE register and make IDCODE the reset opcode.
module jtag_tap_ctrl
   import jtag_tap_pkg::*;
#(
   parameter int IR_WIDTH = 4
`ifdef JTAG_TAP_CTRL_IDCODE_EN
   ,
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_0DB3
`endif
) (
   input  logic       tck_i,
   input  logic       trst_ni,
   input  logic       tms_i,
   input  logic       td_i,
   output logic       td_o,
   output logic       tdo_oe_o,
   output logic       shift_dr_o,
   output logic       capture_dr_o,
   output logic       update_dr_o,
   output logic       memory_sel_o,
   output logic       fifo_sel_o,
   output logic       confreg_sel_o,
   output logic       scan_in_o,
   input  logic       memory_out_i,
   input  logic       fifo_out_i,
   input  logic       confreg_out_i,
   output logic [3:0] tap_state_o
);

   tap_state_e          state;
   logic [IR_WIDTH-1:0] ir_sr;
   logic [IR_WIDTH-1:0] ir;
   logic                bypass_q;
   dr_sel_e             dr_sel;
   logic                dr_tdo;

   jtag_tap_fsm u_fsm (
      .tck_i        (tck_i),
      .trst_ni      (trst_ni),
      .tms_i        (tms_i),
      .state_o      (state),
      .shift_dr_o   (shift_dr_o),
      .capture_dr_o (capture_dr_o),
      .update_dr_o  (update_dr_o)
   );

   assign tap_state_o = state;
   assign scan_in_o   = td_i;

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         ir_sr <= '0;
      end else if (state == CAPTURE_IR) begin
         ir_sr <= IR_WIDTH'(IR_CAPTURE_VALUE);
      end else if (state == SHIFT_IR) begin
         ir_sr <= {td_i, ir_sr[IR_WIDTH-1:1]};
      end
   end

   // IR moves on the falling edge so the new selects settle before the next rising edge
   always_ff @(negedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         ir <= IR_WIDTH'(OP_RESET);
      end else if (state == TEST_LOGIC_RESET) begin
         ir <= IR_WIDTH'(OP_RESET);
      end else if (state == UPDATE_IR) begin
         ir <= ir_sr;
      end
   end

   always_comb begin
      dr_sel = SEL_BYPASS;
      case (ir)
         IR_WIDTH'(OP_MEMORY_ACCESS):  dr_sel = SEL_MEMORY;
         IR_WIDTH'(OP_FIFO_ACCESS):    dr_sel = SEL_FIFO;
         IR_WIDTH'(OP_CONFREG_ACCESS): dr_sel = SEL_CONFREG;
`ifdef JTAG_TAP_CTRL_IDCODE_EN
         IR_WIDTH'(OP_IDCODE):         dr_sel = SEL_IDCODE;
`else
         IR_WIDTH'(OP_IDCODE):         dr_sel = SEL_BYPASS;
`endif
         IR_WIDTH'(OP_EXTEST),
         IR_WIDTH'(OP_SAMPLE_PRELOAD),
         IR_WIDTH'(OP_BYPASS):         dr_sel = SEL_BYPASS;
         default:                      dr_sel = SEL_BYPASS;
      endcase
   end

   assign memory_sel_o  = (dr_sel == SEL_MEMORY);
   assign fifo_sel_o    = (dr_sel == SEL_FIFO);
   assign confreg_sel_o = (dr_sel == SEL_CONFREG);

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         bypass_q <= 1'b0;
      end else if (state == CAPTURE_DR) begin
         bypass_q <= 1'b0;
      end else if (state == SHIFT_DR && dr_sel == SEL_BYPASS) begin
         bypass_q <= td_i;
      end
   end

`ifdef JTAG_TAP_CTRL_IDCODE_EN
   logic [31:0] idcode_sr;

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         idcode_sr <= IDCODE_VALUE;
      end else if (state == CAPTURE_DR) begin
         idcode_sr <= IDCODE_VALUE;
      end else if (state == SHIFT_DR && dr_sel == SEL_IDCODE) begin
         idcode_sr <= {td_i, idcode_sr[31:1]};
      end
   end
`endif

   always_comb begin
      dr_tdo = bypass_q;
      case (dr_sel)
         SEL_MEMORY:  dr_tdo = memory_out_i;
         SEL_FIFO:    dr_tdo = fifo_out_i;
         SEL_CONFREG: dr_tdo = confreg_out_i;
`ifdef JTAG_TAP_CTRL_IDCODE_EN
         SEL_IDCODE:  dr_tdo = idcode_sr[0];
`endif
         default:     dr_tdo = bypass_q;
      endcase
   end

   always_ff @(negedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         td_o     <= 1'b0;
         tdo_oe_o <= 1'b0;
      end else begin
         if (state == SHIFT_IR) begin
            td_o <= ir_sr[0];
         end else if (state == SHIFT_DR) begin
            td_o <= dr_tdo;
         end else begin
            td_o <= 1'b0;
         end
         tdo_oe_o <= (state == SHIFT_IR) || (state == SHIFT_DR);
      end
   end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: vector table, directed scans and a queue-based reference model.
// Build with or without JTAG_TAP_CTRL_IDCODE_EN; expectations follow the macro.
module tb_jtag_tap_ctrl;
   import jtag_tap_pkg::*;

   logic       tck = 1'b0;
   logic       trst_n = 1'b0;
   logic       tms = 1'b1;
   logic       td = 1'b0;
   logic       mem_out = 1'b0;
   logic       fifo_out = 1'b0;
   logic       conf_out = 1'b0;
   logic       td_o, tdo_oe, shift_dr, capture_dr, update_dr;
   logic       memory_sel, fifo_sel, confreg_sel, scan_in;
   logic [3:0] tap_state;

   jtag_tap_ctrl dut (
      .tck_i         (tck),
      .trst_ni       (trst_n),
      .tms_i         (tms),
      .td_i          (td),
      .td_o          (td_o),
      .tdo_oe_o      (tdo_oe),
      .shift_dr_o    (shift_dr),
      .capture_dr_o  (capture_dr),
      .update_dr_o   (update_dr),
      .memory_sel_o  (memory_sel),
      .fifo_sel_o    (fifo_sel),
      .confreg_sel_o (confreg_sel),
      .scan_in_o     (scan_in),
      .memory_out_i  (mem_out),
      .fifo_out_i    (fifo_out),
      .confreg_out_i (conf_out),
      .tap_state_o   (tap_state)
   );

   always #10 tck = ~tck;

`ifdef JTAG_TAP_CTRL_IDCODE_EN
   localparam bit         ID_EN  = 1'b1;
   localparam logic [3:0] RST_OP = 4'b0010;
`else
   localparam bit         ID_EN  = 1'b0;
   localparam logic [3:0] RST_OP = 4'b1111;
`endif
   localparam logic [31:0] ID_VAL = 32'h1000_0DB3;

   int checks = 0;
   int errors = 0;
   int cap_cnt = 0;
   int upd_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: TAP position, IR value and DR contents as bit queues (LSB at the front)
   tap_state_e m_st;
   logic [3:0] m_ir;
   bit         irq[$];
   bit         idq[$];
   bit         m_byp;

   function automatic tap_state_e m_next(input tap_state_e s, input logic t);
      case (s)
         TEST_LOGIC_RESET: return t ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    return t ? SELECT_DR_SCAN : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   return t ? SELECT_IR_SCAN : CAPTURE_DR;
         CAPTURE_DR:       return t ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR:         return t ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR:         return t ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:         return t ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR:         return t ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:        return t ? SELECT_DR_SCAN : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   return t ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       return t ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR:         return t ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR:         return t ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:         return t ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR:         return t ? UPDATE_IR : SHIFT_IR;
         default:          return t ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      endcase
   endfunction

   // 0 bypass, 1 idcode, 2 memory, 3 fifo, 4 confreg
   function automatic int m_sel(input logic [3:0] ir);
      if (ir == 4'b0100) return 2;
      if (ir == 4'b0101) return 3;
      if (ir == 4'b0110) return 4;
      if (ir == 4'b0010 && ID_EN) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_st = TEST_LOGIC_RESET;
      m_ir = RST_OP;
      m_byp = 1'b0;
      irq.delete();
      idq.delete();
   endtask

   task automatic step(input logic t, input logic d);
      int   s;
      logic exp_tdo;
      tms = t;
      td  = d;
      @(posedge tck);
      s = m_sel(m_ir);
      case (m_st)
         CAPTURE_IR: begin
            irq.delete();
            irq.push_back(1'b1); irq.push_back(1'b0); irq.push_back(1'b1); irq.push_back(1'b0);
         end
         SHIFT_IR: begin
            void'(irq.pop_front());
            irq.push_back(d);
         end
         CAPTURE_DR: begin
            m_byp = 1'b0;
            idq.delete();
            for (int i = 0; i < 32; i++) idq.push_back(ID_VAL[i]);
         end
         SHIFT_DR: begin
            if (s == 0) m_byp = d;
            if (s == 1) begin
               void'(idq.pop_front());
               idq.push_back(d);
            end
         end
         default: ;
      endcase
      m_st = m_next(m_st, t);
      @(negedge tck);
      #1;
      if (m_st == UPDATE_IR) for (int i = 0; i < 4; i++) m_ir[i] = irq[i];
      if (m_st == TEST_LOGIC_RESET) m_ir = RST_OP;
      s = m_sel(m_ir);
      exp_tdo = 1'b0;
      if (m_st == SHIFT_IR) exp_tdo = irq[0];
      if (m_st == SHIFT_DR) begin
         case (s)
            1:       exp_tdo = idq[0];
            2:       exp_tdo = mem_out;
            3:       exp_tdo = fifo_out;
            4:       exp_tdo = conf_out;
            default: exp_tdo = m_byp;
         endcase
      end
      chk("state", tap_state, m_st);
      chk("shift_dr", shift_dr, m_st == SHIFT_DR);
      chk("capture_dr", capture_dr, m_st == CAPTURE_DR);
      chk("update_dr", update_dr, m_st == UPDATE_DR);
      chk("memory_sel", memory_sel, s == 2);
      chk("fifo_sel", fifo_sel, s == 3);
      chk("confreg_sel", confreg_sel, s == 4);
      chk("td_o", td_o, exp_tdo);
      chk("tdo_oe", tdo_oe, m_st == SHIFT_IR || m_st == SHIFT_DR);
      chk("scan_in", scan_in, td);
      if (capture_dr) cap_cnt++;
      if (update_dr) upd_cnt++;
   endtask

   // All helpers below start and end in RUN_TEST_IDLE
   task automatic load_ir(input logic [3:0] op);
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(i == 3, op[i]);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   // dout[k] is the k-th td_o bit; mpat[k] is driven on memory_out_i for that bit
   task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] mpat,
                          output logic [31:0] dout);
      dout = '0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      mem_out = mpat[0];
      step(1'b0, 1'b0);
      dout[0] = td_o;
      for (int i = 0; i < n; i++) begin
         if (i < n - 1) mem_out = mpat[i+1];
         step(i == n - 1, din[i]);
         if (i < n - 1) dout[i+1] = td_o;
      end
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      mem_out = 1'b0;
   endtask

   task automatic pulse_reset();
      #3 trst_n = 1'b0;
      tms = 1'b1;
      model_reset();
      #3 trst_n = 1'b1;
   endtask

   typedef struct {
      logic       tms;
      logic       tdi;
      tap_state_e st;
      logic       tdo;
      logic       oe;
      logic [2:0] sel;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [31:0] dout;
      logic [3:0]  ops[6];

      // IR scan of 4'b0110 (CONFREG) from reset, sel = {memory, fifo, confreg}
      tbl[0]  = '{1'b0, 1'b0, RUN_TEST_IDLE,  1'b0, 1'b0, 3'b000};
      tbl[1]  = '{1'b1, 1'b0, SELECT_DR_SCAN, 1'b0, 1'b0, 3'b000};
      tbl[2]  = '{1'b1, 1'b0, SELECT_IR_SCAN, 1'b0, 1'b0, 3'b000};
      tbl[3]  = '{1'b0, 1'b0, CAPTURE_IR,     1'b0, 1'b0, 3'b000};
      tbl[4]  = '{1'b0, 1'b0, SHIFT_IR,       1'b1, 1'b1, 3'b000};
      tbl[5]  = '{1'b0, 1'b0, SHIFT_IR,       1'b0, 1'b1, 3'b000};
      tbl[6]  = '{1'b0, 1'b1, SHIFT_IR,       1'b1, 1'b1, 3'b000};
      tbl[7]  = '{1'b0, 1'b1, SHIFT_IR,       1'b0, 1'b1, 3'b000};
      tbl[8]  = '{1'b1, 1'b0, EXIT1_IR,       1'b0, 1'b0, 3'b000};
      tbl[9]  = '{1'b1, 1'b0, UPDATE_IR,      1'b0, 1'b0, 3'b001};
      tbl[10] = '{1'b0, 1'b0, RUN_TEST_IDLE,  1'b0, 1'b0, 3'b001};

      repeat (2) @(negedge tck);
      #1;
      chk("reset_state", tap_state, 4'hF);
      chk("reset_td_o", td_o, 1'b0);
      chk("reset_oe", tdo_oe, 1'b0);
      chk("reset_sel", {memory_sel, fifo_sel, confreg_sel}, 3'b000);
      model_reset();
      trst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].tms, tbl[i].tdi);
         chk("tbl_state", tap_state, tbl[i].st);
         chk("tbl_td_o", td_o, tbl[i].tdo);
         chk("tbl_oe", tdo_oe, tbl[i].oe);
         chk("tbl_sel", {memory_sel, fifo_sel, confreg_sel}, tbl[i].sel);
      end

      // Bypass: one-clock delay, identical for an undefined opcode
      load_ir(4'b1111);
      dr_scan(4, 32'b1011, 32'h0, dout);
      chk("bypass_seq", dout[3:0], 4'b0110);
      load_ir(4'b1010);
      dr_scan(4, 32'b1011, 32'h0, dout);
      chk("unknown_op_seq", dout[3:0], 4'b0110);

      // Memory chain passes through; one capture and one update strobe per scan
      load_ir(4'b0100);
      chk("memory_sel_loaded", memory_sel, 1'b1);
      cap_cnt = 0;
      upd_cnt = 0;
      dr_scan(4, 32'b0101, 32'b1001, dout);
      chk("memory_seq", dout[3:0], 4'b1001);
      chk("capture_count", cap_cnt, 1);
      chk("update_count", upd_cnt, 1);

      // Asynchronous reset in the middle of a DR shift
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1);
      #3 trst_n = 1'b0;
      #1;
      chk("async_rst_state", tap_state, 4'hF);
      chk("async_rst_td_o", td_o, 1'b0);
      chk("async_rst_oe", tdo_oe, 1'b0);
      chk("async_rst_sel", {memory_sel, fifo_sel, confreg_sel}, 3'b000);
      model_reset();
      tms = 1'b1;
      #2 trst_n = 1'b1;
      step(1'b0, 1'b0);

      // Five TMS=1 clocks from SHIFT_IR
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      chk("in_shift_ir", tap_state, 4'hA);
      repeat (5) step(1'b1, 1'b0);
      chk("tlr_after_5", tap_state, 4'hF);
      step(1'b0, 1'b0);

      // First DR scan after reset
      pulse_reset();
      step(1'b0, 1'b0);
`ifdef JTAG_TAP_CTRL_IDCODE_EN
      dr_scan(32, 32'h0, 32'h0, dout);
      chk("idcode_value", dout, ID_VAL);
      chk("idcode_first_bit", dout[0], 1'b1);
`else
      dr_scan(8, 32'hFF, 32'h0, dout);
      chk("reset_bypass_seq", dout[7:0], 8'hFE);
`endif

      // Random walks after loading assorted opcodes
      ops[0] = 4'b0100; ops[1] = 4'b0101; ops[2] = 4'b0110;
      ops[3] = 4'b0010; ops[4] = 4'b1111; ops[5] = 4'($urandom_range(0, 15));
      for (int r = 0; r < 6; r++) begin
         repeat (5) step(1'b1, 1'b0);
         step(1'b0, 1'b0);
         load_ir(ops[r]);
         for (int k = 0; k < 70; k++) begin
            mem_out  = 1'($urandom_range(0, 1));
            fifo_out = 1'($urandom_range(0, 1));
            conf_out = 1'($urandom_range(0, 1));
            step($urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller that sequences the PULP debug scan chain.
- Runs the 16-state TAP FSM and holds the instruction register (IR).
- Decodes the IR into one-hot data-register selects (memory/AXI, FIFO, confreg, IDCODE, bypass).
- Muxes the selected chain onto TDO.
- Sits between the chip JTAG pads and the data registers (jtagreg instances, AXI debug scan) in the JTAG top level; clocked only by TCK.

Parameters:
IR_WIDTH, 4, instruction register width in bits.
IDCODE_VALUE, 32'h1000_0DB3, device ID shifted out under IDCODE; bit 0 must be 1.

Ports:
tck_i  in  1  JTAG test clock.
trst_ni  in  1  reset; asynchronous, active-low.
tms_i  in  1  test mode select, sampled posedge tck_i.
td_i  in  1  test data in.
td_o  out  1  test data out, updated on negedge tck_i.
tdo_oe_o  out  1  TDO output enable, updated on negedge tck_i.
shift_dr_o  out  1  FSM in SHIFT_DR.
capture_dr_o  out  1  FSM in CAPTURE_DR.
update_dr_o  out  1  FSM in UPDATE_DR.
memory_sel_o  out  1  IR == MEMORY_ACCESS.
fifo_sel_o  out  1  IR == FIFO_ACCESS.
confreg_sel_o  out  1  IR == CONFREG_ACCESS.
scan_in_o  out  1  serial data toward the DRs (= td_i).
memory_out_i  in  1  serial out of the memory/AXI chain.
fifo_out_i  in  1  serial out of the FIFO chain.
confreg_out_i  in  1  serial out of the confreg chain.
tap_state_o  out  4  current FSM state encoding, for debug.

Behaviour:
- FSM: standard 16 states, TEST_LOGIC_RESET through UPDATE_IR, with standard TMS transitions on posedge tck_i.
- Reset (trst_ni low, async):
  - state = TEST_LOGIC_RESET; IR = reset opcode; IR shift register = 0; bypass flop = 0.
  - td_o = 0, tdo_oe_o = 0.
  - Reset takes effect immediately, including mid-shift; no partial IR/DR update is issued.
- Five consecutive TMS=1 clocks reach TEST_LOGIC_RESET from any state. That state also loads the reset opcode into IR synchronously.
- Opcodes (4-bit):
  - EXTEST 0000 and SAMPLE_PRELOAD 0001 both select bypass.
  - IDCODE 0010; MEMORY_ACCESS 0100; FIFO_ACCESS 0101; CONFREG_ACCESS 0110; BYPASS 1111.
  - Any other value selects bypass.
- IR path:
  - CAPTURE_IR loads the shift register with 4'b0101 (LSBs "01" per standard).
  - SHIFT_IR shifts right, td_i into the MSB, LSB toward TDO.
  - IR is updated from the shift register on negedge tck_i while in UPDATE_IR, so selects change mid-cycle, before the next posedge.
- Selects: combinational one-hot decode of IR. All three *_sel_o are 0 unless their opcode is loaded.
- DR strobes: shift/capture/update_dr_o are pure state decodes, asserted for exactly the clocks spent in that state.
- Bypass register: 1 bit; cleared in CAPTURE_DR; loads td_i in SHIFT_DR when bypass is selected.
- IDCODE register: 32 bits; loads IDCODE_VALUE in CAPTURE_DR; shifts right in SHIFT_DR when selected.
- TDO mux, registered on negedge tck_i:
  - SHIFT_IR: IR shift LSB.
  - SHIFT_DR: LSB of the selected DR.
  - Otherwise 0.
  - tdo_oe_o is 1 only in SHIFT_IR/SHIFT_DR.
- Latency: first captured bit appears on td_o half a TCK period after entering a shift state. Bypass gives 1 TCK of delay td_i→td_o.
- IR change while a DR is mid-shift is impossible by construction (IR updates only in UPDATE_IR).

Optional Feature:
Macro JTAG_TAP_CTRL_IDCODE_EN.
- Defined: IDCODE register present; reset opcode = IDCODE, so the first DR scan after reset returns IDCODE_VALUE.
- Undefined: no IDCODE register; opcode 0010 decodes to bypass; reset opcode = BYPASS, so the first DR scan after reset returns a single 0 then echoes td_i.

Decomposition:
- Package jtag_tap_pkg holds:
  - typedef tap_state_e (16-state enum, 4 bits).
  - Opcode localparams and IR_CAPTURE_VALUE = 4'b0101.
  - DR select enum: BYPASS, IDCODE, MEMORY, FIFO, CONFREG.
- One natural sub-module: jtag_tap_fsm (state register + next-state logic + state-decode outputs). IR, DRs and the TDO mux stay in the top module.

Test Plan:
- Reset: assert trst_ni mid-SHIFT_DR → tap_state_o = TEST_LOGIC_RESET immediately, td_o = 0, tdo_oe_o = 0, all *_sel_o = 0. Then 5×TMS=1 from SHIFT_IR → TEST_LOGIC_RESET.
- IR capture/load: shift IR with td_i = 4'b0110 → first 4 td_o bits = 1,0,1,0 (LSB first); after UPDATE_IR, confreg_sel_o = 1, others 0.
- IDCODE (macro defined): reset, then DR scan of 32 bits → td_o sequence equals IDCODE_VALUE LSB first, first bit 1.
- Bypass: load IR 1111, shift DR pattern 1,1,0,1 → td_o = 0,1,1,0 (one-clock delay). Repeat with unknown opcode 1010 → identical result.
- DR sequencing: IR = MEMORY_ACCESS, drive memory_out_i = 1,0,0,1 → td_o mirrors the pattern. capture_dr_o is 1 for exactly 1 clock; update_dr_o is 1 for exactly 1 clock after EXIT1_DR; scan_in_o follows td_i.
- Macro off: reset, DR scan of 8 bits with td_i = 8'hFF → td_o = 0 then seven 1s.
